conv_window_scanner: RTL and testbench

//   Upstream sequencer for the 3x3 patch latch.
//   - Raster-scans a 3x3 window across an IMG_W x IMG_H 8-bit feature map in pixel RAM.
//   - Drives the 9 pixel addresses and the load/load_full_patch controls.
//   - Waits for load_done, then presents each patch to the MAC stage with a valid/ready handshake.
//   - Issues a full 9-pixel load at each row start; otherwise a 3-pixel column-shift load.

---
 rtl/conv_pkg.sv | 23 ++
 rtl/conv_win_addr.sv | 66 ++++++
 rtl/conv_window_scanner.sv | 208 ++++++++++++++++++++
 tb/tb_conv_window_scanner.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared constants and state encoding for the 3x3 window scanner
//
// Purpose : default feature-map geometry, FSM state encoding and patch layout
//           constants used by conv_window_scanner and conv_win_addr.
// Ports   : none (package).
package conv_pkg;

  localparam int CONV_IMG_W  = 28;
  localparam int CONV_IMG_H  = 28;
  localparam int CONV_ADDR_W = 10;

  // Patch layout: pixel index = PATCH_SIDE*col + row, PATCH_PIX pixels total.
  localparam int PATCH_SIDE = 3;
  localparam int PATCH_PIX  = PATCH_SIDE * PATCH_SIDE;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_PRESENT = 2'd3
  } conv_state_e;

endpackage

// File: rtl/conv_win_addr.sv
// rtl/conv_win_addr.sv - window base tracker producing the nine patch pixel addresses
//
// Purpose : holds the RAM address of the current window's top-left pixel and of
//           the current row start; derives all nine pixel addresses from it.
// Ports   : clk, rst        clock, asynchronous active-high reset
//           init            reload base and row start with BASE (scan start)
//           step            move the window one column right
//           wrap            move the window to column 0 of the next row
//           pixel_addr[9]   window addresses, index PATCH_SIDE*c + r
module conv_win_addr
  import conv_pkg::*;
#(
  parameter int IMG_W  = CONV_IMG_W,
  parameter int ADDR_W = CONV_ADDR_W,
  parameter int BASE   = 0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 init,
  input  logic                                 step,
  input  logic                                 wrap,
  output logic [PATCH_PIX-1:0][ADDR_W-1:0]     pixel_addr
);

  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE);
  localparam logic [ADDR_W-1:0] ROW_A  = ADDR_W'(IMG_W);

  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] row_start_q, row_start_d;

  always_comb begin
    base_d      = base_q;
    row_start_d = row_start_q;
    if (init) begin
      base_d      = BASE_A;
      row_start_d = BASE_A;
    end else if (wrap) begin
      base_d      = row_start_q + ROW_A;
      row_start_d = row_start_q + ROW_A;
    end else if (step) begin
      base_d      = base_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q      <= BASE_A;
      row_start_q <= BASE_A;
    end else begin
      base_q      <= base_d;
      row_start_q <= row_start_d;
    end
  end

  // Offsets r*IMG_W + c are elaboration-time constants, so each address is a
  // single adder off the base.
  always_comb begin
    pixel_addr = '0;
    for (int c = 0; c < PATCH_SIDE; c++) begin
      for (int r = 0; r < PATCH_SIDE; r++) begin
        pixel_addr[PATCH_SIDE*c + r] = base_q + ADDR_W'(r * IMG_W + c);
      end
    end
  end

endmodule

// File: rtl/conv_window_scanner.sv
// rtl/conv_window_scanner.sv - raster-scan sequencer feeding the 3x3 patch latch
//
// Purpose : scans a 3x3 window over an IMG_W x IMG_H map, requests full or
//           column-shift loads from the patch latch, and hands each patch to
//           the MAC stage with a valid/ready handshake.
// Ports   : clk, rst                 clock, asynchronous active-high reset
//           start / busy / done      scan control and status
//           load, load_full_patch    latch request, full (1) or shift (0) load
//           load_done                latch completion strobe
//           pixel_addr0..8           window addresses, index 3*c + r
//           patch_valid/patch_ready  patch handshake to the MAC stage
//           out_row, out_col         top-left coordinate of the current patch
//           stall_cycles             valid-but-not-ready cycle count
// Option  : CONV_SCAN_STALL_CNT_EN builds the saturating stall counter;
//           otherwise stall_cycles is tied to zero.
module conv_window_scanner
  import conv_pkg::*;
#(
  parameter int IMG_W  = CONV_IMG_W,
  parameter int IMG_H  = CONV_IMG_H,
  parameter int ADDR_W = CONV_ADDR_W,
  parameter int BASE   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              load,
  output logic              load_full_patch,
  input  logic              load_done,
  output logic [ADDR_W-1:0] pixel_addr0,
  output logic [ADDR_W-1:0] pixel_addr1,
  output logic [ADDR_W-1:0] pixel_addr2,
  output logic [ADDR_W-1:0] pixel_addr3,
  output logic [ADDR_W-1:0] pixel_addr4,
  output logic [ADDR_W-1:0] pixel_addr5,
  output logic [ADDR_W-1:0] pixel_addr6,
  output logic [ADDR_W-1:0] pixel_addr7,
  output logic [ADDR_W-1:0] pixel_addr8,
  output logic              patch_valid,
  input  logic              patch_ready,
  output logic [7:0]        out_row,
  output logic [7:0]        out_col,
  output logic [15:0]       stall_cycles
);

  localparam logic [1:0] S_IDLE    = ST_IDLE;
  localparam logic [1:0] S_ISSUE   = ST_ISSUE;
  localparam logic [1:0] S_WAIT    = ST_WAIT;
  localparam logic [1:0] S_PRESENT = ST_PRESENT;

  localparam logic [7:0] LAST_COL = 8'(IMG_W - 3);
  localparam logic [7:0] LAST_ROW = 8'(IMG_H - 3);

  logic [1:0] state_q, state_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       load_q, load_d;
  logic       full_q, full_d;
  logic       valid_q, valid_d;
  logic [7:0] row_q, row_d;
  logic [7:0] col_q, col_d;

  logic start_ok, accept, at_last_col, last_patch, step, wrap;
  logic [PATCH_PIX-1:0][ADDR_W-1:0] addr;

  assign start_ok    = (state_q == S_IDLE) && start;
  assign accept      = (state_q == S_PRESENT) && valid_q && patch_ready;
  assign at_last_col = (col_q == LAST_COL);
  assign last_patch  = at_last_col && (row_q == LAST_ROW);
  assign step        = accept && !last_patch && !at_last_col;
  assign wrap        = accept && !last_patch && at_last_col;

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    load_d  = load_q;
    full_d  = full_q;
    valid_d = valid_q;
    row_d   = row_q;
    col_d   = col_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ISSUE;
          busy_d  = 1'b1;
          full_d  = 1'b1;
          row_d   = 8'd0;
          col_d   = 8'd0;
        end
      end
      S_ISSUE: begin
        load_d  = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Dropping load on the same edge lets the latch see load&&load_done
        // exactly once and retire its strobe.
        if (load_done) begin
          load_d  = 1'b0;
          valid_d = 1'b1;
          state_d = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (accept) begin
          valid_d = 1'b0;
          if (last_patch) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = S_ISSUE;
            if (at_last_col) begin
              col_d  = 8'd0;
              row_d  = row_q + 8'd1;
              full_d = 1'b1;
            end else begin
              col_d  = col_q + 8'd1;
              full_d = 1'b0;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      load_q  <= 1'b0;
      full_q  <= 1'b0;
      valid_q <= 1'b0;
      row_q   <= 8'd0;
      col_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      load_q  <= load_d;
      full_q  <= full_d;
      valid_q <= valid_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  conv_win_addr #(
    .IMG_W (IMG_W),
    .ADDR_W(ADDR_W),
    .BASE  (BASE)
  ) u_addr (
    .clk       (clk),
    .rst       (rst),
    .init      (start_ok),
    .step      (step),
    .wrap      (wrap),
    .pixel_addr(addr)
  );

`ifdef CONV_SCAN_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (start_ok) begin
      stall_d = 16'd0;
    end else if (valid_q && !patch_ready && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_q <= 16'd0;
    else     stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 16'd0;
`endif

  assign busy            = busy_q;
  assign done            = done_q;
  assign load            = load_q;
  assign load_full_patch = full_q;
  assign patch_valid     = valid_q;
  assign out_row         = row_q;
  assign out_col         = col_q;

  // Addresses are only meaningful during a scan; outside it they read as zero
  // so every output is quiet after reset.
  assign pixel_addr0 = busy_q ? addr[0] : '0;
  assign pixel_addr1 = busy_q ? addr[1] : '0;
  assign pixel_addr2 = busy_q ? addr[2] : '0;
  assign pixel_addr3 = busy_q ? addr[3] : '0;
  assign pixel_addr4 = busy_q ? addr[4] : '0;
  assign pixel_addr5 = busy_q ? addr[5] : '0;
  assign pixel_addr6 = busy_q ? addr[6] : '0;
  assign pixel_addr7 = busy_q ? addr[7] : '0;
  assign pixel_addr8 = busy_q ? addr[8] : '0;

endmodule

// File: tb/tb_conv_window_scanner.sv
// tb/tb_conv_window_scanner.sv - self-checking bench for conv_window_scanner with latch and RAM models
module tb_conv_window_scanner;

  localparam int W      = 5;
  localparam int H      = 4;
  localparam int AW     = 10;
  localparam int NPATCH = (W - 2) * (H - 2);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          patch_ready = 1'b0;
  logic          load_done;
  logic          busy, done, load, load_full_patch, patch_valid;
  logic [AW-1:0] pa [9];
  logic [7:0]    out_row, out_col;
  logic [15:0]   stall_cycles;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  conv_window_scanner #(
    .IMG_W (W),
    .IMG_H (H),
    .ADDR_W(AW),
    .BASE  (0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .load           (load),
    .load_full_patch(load_full_patch),
    .load_done      (load_done),
    .pixel_addr0    (pa[0]),
    .pixel_addr1    (pa[1]),
    .pixel_addr2    (pa[2]),
    .pixel_addr3    (pa[3]),
    .pixel_addr4    (pa[4]),
    .pixel_addr5    (pa[5]),
    .pixel_addr6    (pa[6]),
    .pixel_addr7    (pa[7]),
    .pixel_addr8    (pa[8]),
    .patch_valid    (patch_valid),
    .patch_ready    (patch_ready),
    .out_row        (out_row),
    .out_col        (out_col),
    .stall_cycles   (stall_cycles)
  );

  function automatic logic [7:0] ram_val(input int a);
    return 8'((a * 37 + 11) % 256);
  endfunction

  // Patch latch model: full load takes 4 cycles, shift load 2, then holds
  // load_done until it sees load && load_done.
  logic [7:0] lat_q [9];
  logic       lat_busy;
  int         lat_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      load_done <= 1'b0;
      lat_busy  <= 1'b0;
      lat_cnt   <= 0;
    end else if (load_done) begin
      if (load) load_done <= 1'b0;
    end else if (lat_busy) begin
      if (lat_cnt == 0) begin
        lat_busy  <= 1'b0;
        load_done <= 1'b1;
        if (load_full_patch) begin
          for (int i = 0; i < 9; i++) lat_q[i] <= ram_val(int'(pa[i]));
        end else begin
          for (int i = 0; i < 6; i++) lat_q[i] <= lat_q[i+3];
          for (int i = 6; i < 9; i++) lat_q[i] <= ram_val(int'(pa[i]));
        end
      end else begin
        lat_cnt <= lat_cnt - 1;
      end
    end else if (load) begin
      lat_busy <= 1'b1;
      lat_cnt  <= load_full_patch ? 3 : 1;
    end
  end

  typedef struct packed { logic full; logic [8:0][AW-1:0] a; } load_t;
  typedef struct packed { logic [7:0] row; logic [7:0] col; logic [8:0][7:0] d; } patch_t;
  typedef struct packed { logic [7:0] row; logic [7:0] col; logic full; } exp_t;

  load_t  obs_ld [$];
  patch_t obs_pt [$];
  exp_t   exp_q  [$];
  int     done_cnt, overlap_cnt, acc_cnt, done_cyc, start_cyc, ref_cycles;
  logic   load_prev;
  load_t  mon_l;
  patch_t mon_p;

  always @(negedge clk) begin
    if (rst) begin
      load_prev = 1'b0;
    end else begin
      if (load && !load_prev) begin
        mon_l.full = load_full_patch;
        for (int i = 0; i < 9; i++) mon_l.a[i] = pa[i];
        obs_ld.push_back(mon_l);
      end
      load_prev = load;
      if (patch_valid && patch_ready) begin
        mon_p.row = out_row;
        mon_p.col = out_col;
        for (int i = 0; i < 9; i++) mon_p.d[i] = lat_q[i];
        obs_pt.push_back(mon_p);
        acc_cnt++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (load && patch_valid) overlap_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    obs_ld.delete();
    obs_pt.delete();
    exp_q.delete();
    done_cnt = 0;
    overlap_cnt = 0;
    acc_cnt = 0;
  endtask

  task automatic push_expected();
    for (int r = 0; r < H - 2; r++)
      for (int c = 0; c < W - 2; c++)
        exp_q.push_back('{row: 8'(r), col: 8'(c), full: (c == 0)});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start_cyc = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      tick();
      if (done_cnt > 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      if (patch_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
    n_vec++; if (load !== 1'b0) begin n_err++; $display("FAIL reset_load: got %b expected 0", load); end
    n_vec++; if (load_full_patch !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b expected 0", load_full_patch); end
    n_vec++; if (patch_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", patch_valid); end
    n_vec++; if ({out_row, out_col} !== 16'd0) begin n_err++; $display("FAIL reset_rowcol: got %0d,%0d expected 0,0", out_row, out_col); end
    n_vec++; if (stall_cycles !== 16'd0) begin n_err++; $display("FAIL reset_stall: got %0d expected 0", stall_cycles); end
    for (int i = 0; i < 9; i++) begin
      n_vec++; if (pa[i] !== '0) begin n_err++; $display("FAIL reset_addr%0d: got %0d expected 0", i, pa[i]); end
    end
    rst = 1'b0;
    tick();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_first_patch();
    bit ok;
    int exp_first [9];
    logic [8:0][7:0] exp_d;
    exp_first = '{0, 5, 10, 1, 6, 11, 2, 7, 12};
    clear_obs();
    patch_ready = 1'b0;
    pulse_start();
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL first_busy: got %b expected 1", busy); end
    wait_valid(200, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL first_valid_timeout: got no patch_valid expected 1 within 200 cycles"); end
    n_vec++; if (obs_ld.size() !== 1) begin n_err++; $display("FAIL first_load_count: got %0d expected 1", obs_ld.size()); end
    if (obs_ld.size() > 0) begin
      n_vec++; if (obs_ld[0].full !== 1'b1) begin n_err++; $display("FAIL first_full: got %b expected 1", obs_ld[0].full); end
      for (int i = 0; i < 9; i++) begin
        n_vec++;
        if (obs_ld[0].a[i] !== AW'(exp_first[i])) begin
          n_err++; $display("FAIL first_addr%0d: got %0d expected %0d", i, obs_ld[0].a[i], exp_first[i]);
        end
      end
    end
    n_vec++; if ({out_row, out_col} !== 16'd0) begin n_err++; $display("FAIL first_rowcol: got %0d,%0d expected 0,0", out_row, out_col); end
    for (int i = 0; i < 9; i++) exp_d[i] = ram_val(exp_first[i]);
    n_vec++;
    if ({lat_q[8], lat_q[7], lat_q[6], lat_q[5], lat_q[4], lat_q[3], lat_q[2], lat_q[1], lat_q[0]} !== exp_d) begin
      n_err++; $display("FAIL first_data: got %h %h %h expected %h", lat_q[0], lat_q[4], lat_q[8], exp_d);
    end
    patch_ready = 1'b1;
    wait_done(600, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL first_done_timeout: got no done expected done"); end
    tick();
  endtask

  task automatic test_full_scan();
    bit ok;
    exp_t e;
    patch_t p;
    load_t l;
    logic [8:0][7:0] exp_d;
    logic [8:0][AW-1:0] exp_a;
    int k;
    clear_obs();
    push_expected();
    patch_ready = 1'b1;
    pulse_start();
    wait_done(600, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL scan_done_timeout: got no done expected done"); end
    ref_cycles = done_cyc - start_cyc;
    tick(); tick(); tick();
    n_vec++; if (obs_pt.size() !== NPATCH) begin n_err++; $display("FAIL scan_patch_count: got %0d expected %0d", obs_pt.size(), NPATCH); end
    n_vec++; if (obs_ld.size() !== NPATCH) begin n_err++; $display("FAIL scan_load_count: got %0d expected %0d", obs_ld.size(), NPATCH); end
    n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL scan_done_pulses: got %0d expected 1", done_cnt); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL scan_busy_end: got %b expected 0", busy); end
    k = 0;
    while (exp_q.size() > 0 && obs_pt.size() > 0 && obs_ld.size() > 0) begin
      e = exp_q.pop_front();
      p = obs_pt.pop_front();
      l = obs_ld.pop_front();
      for (int c = 0; c < 3; c++)
        for (int r = 0; r < 3; r++) begin
          exp_a[3*c+r] = AW'((int'(e.row) + r) * W + int'(e.col) + c);
          exp_d[3*c+r] = ram_val((int'(e.row) + r) * W + int'(e.col) + c);
        end
      n_vec++; if ({p.row, p.col} !== {e.row, e.col}) begin n_err++; $display("FAIL scan_pos%0d: got %0d,%0d expected %0d,%0d", k, p.row, p.col, e.row, e.col); end
      n_vec++; if (l.full !== e.full) begin n_err++; $display("FAIL scan_full%0d: got %b expected %b", k, l.full, e.full); end
      n_vec++; if (l.a !== exp_a) begin n_err++; $display("FAIL scan_addr%0d: got %h expected %h", k, l.a, exp_a); end
      n_vec++; if (p.d !== exp_d) begin n_err++; $display("FAIL scan_data%0d: got %h expected %h", k, p.d, exp_d); end
      k++;
    end
  endtask

  task automatic test_shift_load();
    bit ok;
    logic [8:0][7:0] exp_d;
    clear_obs();
    patch_ready = 1'b1;
    pulse_start();
    wait_done(600, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL shift_done_timeout: got no done expected done"); end
    tick();
    if (obs_ld.size() > 1 && obs_pt.size() > 1) begin
      n_vec++; if (obs_ld[1].full !== 1'b0) begin n_err++; $display("FAIL shift_full: got %b expected 0", obs_ld[1].full); end
      n_vec++;
      if ({obs_ld[1].a[6], obs_ld[1].a[7], obs_ld[1].a[8]} !== {AW'(3), AW'(8), AW'(13)}) begin
        n_err++; $display("FAIL shift_addr678: got %0d,%0d,%0d expected 3,8,13", obs_ld[1].a[6], obs_ld[1].a[7], obs_ld[1].a[8]);
      end
      for (int c = 0; c < 3; c++)
        for (int r = 0; r < 3; r++) exp_d[3*c+r] = ram_val(r * W + 1 + c);
      n_vec++; if (obs_pt[1].d !== exp_d) begin n_err++; $display("FAIL shift_data: got %h expected %h", obs_pt[1].d, exp_d); end
    end else begin
      n_vec++; n_err++; $display("FAIL shift_obs: got %0d loads expected at least 2", obs_ld.size());
    end
  endtask

  task automatic test_stall();
    int hold;
    int n;
    logic [8:0][AW-1:0] snap, cur;
    clear_obs();
    hold = 0;
    n = 0;
    patch_ready = 1'b1;
    pulse_start();
    while (done_cnt == 0 && n < 800) begin
      for (int i = 0; i < 9; i++) cur[i] = pa[i];
      if (acc_cnt == 2 && (patch_valid || hold > 0) && hold < 10) begin
        if (hold == 0) begin
          snap = cur;
        end else begin
          n_vec++; if (patch_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid: got %b expected 1", patch_valid); end
          n_vec++; if (load !== 1'b0) begin n_err++; $display("FAIL stall_load: got %b expected 0", load); end
          n_vec++; if (cur !== snap) begin n_err++; $display("FAIL stall_addr: got %h expected %h", cur, snap); end
        end
        patch_ready = 1'b0;
        hold++;
      end else begin
        patch_ready = 1'b1;
      end
      tick();
      n++;
    end
    patch_ready = 1'b1;
    n_vec++; if (done_cnt == 0) begin n_err++; $display("FAIL stall_done_timeout: got no done expected done"); end
    n_vec++; if (hold !== 10) begin n_err++; $display("FAIL stall_hold: got %0d expected 10", hold); end
    n_vec++; if (acc_cnt !== NPATCH) begin n_err++; $display("FAIL stall_patch_count: got %0d expected %0d", acc_cnt, NPATCH); end
    n_vec++; if (overlap_cnt !== 0) begin n_err++; $display("FAIL stall_overlap: got %0d expected 0", overlap_cnt); end
`ifdef CONV_SCAN_STALL_CNT_EN
    n_vec++; if (stall_cycles !== 16'd10) begin n_err++; $display("FAIL stall_cycles: got %0d expected 10", stall_cycles); end
`else
    n_vec++; if (stall_cycles !== 16'd0) begin n_err++; $display("FAIL stall_cycles: got %0d expected 0", stall_cycles); end
`endif
    tick();
  endtask

  task automatic test_reset_mid();
    bit ok;
    int dc;
    int n;
    clear_obs();
    patch_ready = 1'b1;
    pulse_start();
    ok = 1'b0;
    for (n = 0; n < 400; n++) begin
      if (acc_cnt == 4 && load) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    n_vec++; if (!ok) begin n_err++; $display("FAIL rmid_reach_wait: got no WAIT of patch 4 expected one"); end
    rst = 1'b1;
    tick();
    n_vec++; if ({busy, done, load, load_full_patch, patch_valid} !== 5'b0) begin n_err++; $display("FAIL rmid_ctrl: got %b expected 00000", {busy, done, load, load_full_patch, patch_valid}); end
    n_vec++; if ({out_row, out_col, stall_cycles} !== 32'd0) begin n_err++; $display("FAIL rmid_status: got %0d,%0d,%0d expected 0,0,0", out_row, out_col, stall_cycles); end
    n_vec++; if ({pa[0], pa[4], pa[8]} !== '0) begin n_err++; $display("FAIL rmid_addr: got %0d,%0d,%0d expected 0,0,0", pa[0], pa[4], pa[8]); end
    rst = 1'b0;
    dc = done_cnt;
    tick(); tick();
    n_vec++; if (done_cnt !== dc) begin n_err++; $display("FAIL rmid_no_done: got %0d pulses expected %0d", done_cnt, dc); end
    clear_obs();
    pulse_start();
    wait_valid(200, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL rmid_valid_timeout: got no patch_valid expected 1"); end
    n_vec++; if ({out_row, out_col} !== 16'd0) begin n_err++; $display("FAIL rmid_restart_pos: got %0d,%0d expected 0,0", out_row, out_col); end
    if (obs_ld.size() > 0) begin
      n_vec++; if ({obs_ld[0].full, obs_ld[0].a[0], obs_ld[0].a[8]} !== {1'b1, AW'(0), AW'(12)}) begin
        n_err++; $display("FAIL rmid_restart_load: got full=%b a0=%0d a8=%0d expected full=1 a0=0 a8=12", obs_ld[0].full, obs_ld[0].a[0], obs_ld[0].a[8]);
      end
    end else begin
      n_vec++; n_err++; $display("FAIL rmid_restart_load: got 0 loads expected 1");
    end
    wait_done(600, ok);
    n_vec++; if (acc_cnt !== NPATCH) begin n_err++; $display("FAIL rmid_patch_count: got %0d expected %0d", acc_cnt, NPATCH); end
    tick();
  endtask

  task automatic test_start_busy();
    bit ok;
    int n;
    exp_t e;
    patch_t p;
    clear_obs();
    push_expected();
    patch_ready = 1'b1;
    pulse_start();
    ok = 1'b0;
    for (n = 0; n < 600; n++) begin
      start = busy && (n % 3 == 0);
      tick();
      if (done_cnt > 0) begin
        ok = 1'b1;
        break;
      end
    end
    start = 1'b0;
    tick(); tick(); tick();
    n_vec++; if (!ok) begin n_err++; $display("FAIL sbusy_done_timeout: got no done expected done"); end
    n_vec++; if (acc_cnt !== NPATCH) begin n_err++; $display("FAIL sbusy_patch_count: got %0d expected %0d", acc_cnt, NPATCH); end
    n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL sbusy_done_pulses: got %0d expected 1", done_cnt); end
    n_vec++; if (done_cyc - start_cyc !== ref_cycles) begin n_err++; $display("FAIL sbusy_timing: got %0d cycles expected %0d", done_cyc - start_cyc, ref_cycles); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL sbusy_busy_end: got %b expected 0", busy); end
    while (exp_q.size() > 0 && obs_pt.size() > 0) begin
      e = exp_q.pop_front();
      p = obs_pt.pop_front();
      n_vec++; if ({p.row, p.col} !== {e.row, e.col}) begin n_err++; $display("FAIL sbusy_pos: got %0d,%0d expected %0d,%0d", p.row, p.col, e.row, e.col); end
    end
  endtask

  initial begin
    test_reset();
    test_first_patch();
    test_full_scan();
    test_shift_load();
    test_stall();
    test_reset_mid();
    test_start_busy();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
